// File: rtl/pixel_frame_writer.sv
// Raster-order frame buffer writer with valid/ready pixel input and a registered read port.
// Optional CHECKSUM_EN macro enables a running 16-bit pixel sum on the checksum output.
module pixel_frame_writer #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [ADDR_W:0]   pix_count,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic [15:0]       checksum
);
    localparam int TOTAL = IMG_W * IMG_H;
    localparam logic [ADDR_W:0]   LAST_PIX = (ADDR_W+1)'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    state_t state;

    logic [PIX_W-1:0] mem [0:(2**ADDR_W)-1];
    logic             accept;
    logic             rd_in_range;

    // pix_ready is only ever high in CAPTURE, so accept implies CAPTURE.
    assign accept      = pix_valid & pix_ready;
    assign rd_in_range = (int'({1'b0, rd_addr}) < TOTAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            pix_count  <= '0;
            row        <= '0;
            col        <= '0;
        end else if (start) begin
            // start overrides any coincident accept: the pixel is dropped.
            state      <= CAPTURE;
            pix_ready  <= 1'b1;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            pix_count  <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (accept) begin
                        pix_count <= pix_count + 1'b1;
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (pix_count == LAST_PIX) begin
                            state      <= DONE;
                            pix_ready  <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (pix_valid) overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !start && !rst) mem[pix_count[ADDR_W-1:0]] <= pix_in;
    end

    // Read-first: the non-blocking write above is not visible to a same-cycle read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

`ifdef CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + 16'(pix_in);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer: a 64x64 instance plus a 2x2 instance for checksum.
module tb_pixel_frame_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [12:0] pix_count;
    logic [11:0] row;
    logic [11:0] col;
    logic [15:0] checksum;

    logic        s_start;
    logic [7:0]  s_pix_in;
    logic        s_pix_valid;
    logic        s_pix_ready;
    logic        s_rd_en;
    logic [2:0]  s_rd_addr;
    logic [7:0]  s_rd_data;
    logic        s_busy;
    logic        s_frame_done;
    logic        s_overrun;
    logic [3:0]  s_pix_count;
    logic [2:0]  s_row;
    logic [2:0]  s_col;
    logic [15:0] s_checksum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pixel_frame_writer #(.PIX_W(8), .IMG_W(64), .IMG_H(64), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .pix_count(pix_count),
        .row(row), .col(col), .checksum(checksum)
    );

    pixel_frame_writer #(.PIX_W(8), .IMG_W(2), .IMG_H(2), .ADDR_W(3)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .pix_in(s_pix_in), .pix_valid(s_pix_valid),
        .pix_ready(s_pix_ready), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .busy(s_busy), .frame_done(s_frame_done), .overrun(s_overrun), .pix_count(s_pix_count),
        .row(s_row), .col(s_col), .checksum(s_checksum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_in = 8'h00; pix_valid = 1'b1; rd_en = 1'b0; rd_addr = '0;
        s_start = 1'b0; s_pix_in = 8'h00; s_pix_valid = 1'b0; s_rd_en = 1'b0; s_rd_addr = '0;

        // Reset with pix_valid asserted
        tick(); tick();
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_pix_count", 32'(pix_count), 32'd0);
        chk("rst_row_col", {row, col}, 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        pix_valid = 1'b0;

        // Full frame, pixel value = address low byte
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ready", 32'(pix_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        pix_valid = 1'b1;
        for (int i = 0; i < 4095; i++) begin
            pix_in = 8'(i);
            tick();
        end
        chk("pre_last_ready", 32'(pix_ready), 32'd1);
        chk("pre_last_done", 32'(frame_done), 32'd0);
        chk("pre_last_row", 32'(row), 32'd63);
        chk("pre_last_col", 32'(col), 32'd63);
        pix_in = 8'hFF;
        tick();
        pix_valid = 1'b0;
        chk("f1_frame_done", 32'(frame_done), 32'd1);
        chk("f1_pix_count", 32'(pix_count), 32'd4096);
        chk("f1_pix_ready", 32'(pix_ready), 32'd0);
        chk("f1_busy", 32'(busy), 32'd0);
        chk("f1_row", 32'(row), 32'd64);
        chk("f1_col", 32'(col), 32'd0);
        chk("f1_overrun", 32'(overrun), 32'd0);
`ifdef CHECKSUM_EN
        chk("f1_checksum", 32'(checksum), 32'h0000F800);
`else
        chk("f1_checksum", 32'(checksum), 32'd0);
`endif
        rd(12'd300);
        chk("rd_300", 32'(rd_data), 32'h2C);
        rd(12'd4095);
        chk("rd_4095", 32'(rd_data), 32'hFF);
        rd_addr = 12'd5;
        tick();
        chk("rd_hold", 32'(rd_data), 32'hFF);

        // Overrun in DONE
        pix_valid = 1'b1; pix_in = 8'hAA; tick(); pix_valid = 1'b0;
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_count", 32'(pix_count), 32'd4096);
        rd(12'd0);
        chk("ovr_mem0", 32'(rd_data), 32'h00);

        // Toggling valid, pixel k = 0x80 + k
        start = 1'b1; tick(); start = 1'b0;
        chk("s2_overrun_clr", 32'(overrun), 32'd0);
        chk("s2_done_clr", 32'(frame_done), 32'd0);
        for (int k = 0; k < 70; k++) begin
            pix_valid = 1'b1; pix_in = 8'(8'h80 + k); tick();
            pix_valid = 1'b0; pix_in = 8'h11; tick();
        end
        chk("tog_count", 32'(pix_count), 32'd70);
        chk("tog_row", 32'(row), 32'd1);
        chk("tog_col", 32'(col), 32'd6);
        for (int k = 70; k < 100; k++) begin
            pix_valid = 1'b1; pix_in = 8'(8'h80 + k); tick();
        end
        chk("pre_restart_count", 32'(pix_count), 32'd100);

        // start coincident with an accept
        start = 1'b1; pix_in = 8'h77; tick(); start = 1'b0; pix_valid = 1'b0;
        chk("restart_count", 32'(pix_count), 32'd0);
        chk("restart_rowcol", {row, col}, 32'd0);
        chk("restart_ready", 32'(pix_ready), 32'd1);
        chk("restart_checksum", 32'(checksum), 32'd0);
        pix_valid = 1'b1; pix_in = 8'h5A; rd_en = 1'b1; rd_addr = 12'd0;
        tick();
        pix_valid = 1'b0; rd_en = 1'b0;
        chk("read_first", 32'(rd_data), 32'h80);
        chk("restart_accept_count", 32'(pix_count), 32'd1);
        rd(12'd0);
        chk("restart_addr0", 32'(rd_data), 32'h5A);
        rd(12'd100);
        chk("dropped_pixel", 32'(rd_data), 32'h64);
        rd(12'd99);
        chk("rd_99", 32'(rd_data), 32'hE3);

        // rst mid-frame, then valid in IDLE
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_ready", 32'(pix_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(pix_count), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        pix_valid = 1'b1; pix_in = 8'hCC; tick(); tick(); pix_valid = 1'b0;
        chk("idle_overrun", 32'(overrun), 32'd0);
        chk("idle_count", 32'(pix_count), 32'd0);
        rd(12'd1);
        chk("idle_mem1", 32'(rd_data), 32'h81);

        // 2x2 frame for checksum
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_pix_valid = 1'b1;
        s_pix_in = 8'hFF; tick();
        s_pix_in = 8'hFF; tick();
        chk("s_row_col", {16'(s_row), 16'(s_col)}, {16'd1, 16'd0});
        s_pix_in = 8'hFF; tick();
        s_pix_in = 8'h03; tick();
        s_pix_valid = 1'b0;
        chk("s_frame_done", 32'(s_frame_done), 32'd1);
        chk("s_pix_count", 32'(s_pix_count), 32'd4);
`ifdef CHECKSUM_EN
        chk("s_checksum", 32'(s_checksum), 32'h0300);
`else
        chk("s_checksum", 32'(s_checksum), 32'h0000);
`endif
        s_rd_en = 1'b1; s_rd_addr = 3'd3; tick();
        chk("s_rd_3", 32'(s_rd_data), 32'h03);
        s_rd_addr = 3'd5; tick(); s_rd_en = 1'b0;
        chk("s_rd_oob", 32'(s_rd_data), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
